// File: rtl/dcache1_victim_queue.sv
// dcache1_victim_queue: FIFO of dirty victim line addresses awaiting L2 write-back.
// Captures the victim driven on the shared wb_addr/wb_valid bus during a fill,
// presents entries in order on the L2 write-back port, and offers a snoop
// comparator so loads can detect a line that is still pending write-back.
// Ports:
//   clk, rst            clock (state updates on negedge), async active-high reset
//   in_wen/in_addr/     fill-cycle strobe, victim address, victim tag valid,
//   in_valid/in_dirty   victim dirty flag; only dirty valid victims are queued
//   fill_stall          queue is one entry from full (or full)
//   out_req/out_addr    head-of-queue write-back request and address
//   out_ack             L2 accepts the head entry
//   snoop_addr/hit      line address compare against all occupied entries
//   count               occupied entries, 0..DEPTH
//   ovf_err             sticky flag: a dirty victim was dropped on a full queue
module dcache1_victim_queue #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int ADDR_W = 37
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_wen,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_valid,
    input  logic              in_dirty,
    output logic              fill_stall,
    output logic              out_req,
    output logic [ADDR_W-1:0] out_addr,
    input  logic              out_ack,
    input  logic [ADDR_W-2:0] snoop_addr,
    output logic              snoop_hit,
    output logic [PTR_W:0]    count,
    output logic              ovf_err
);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              enq, deq, full, accept;

    assign out_req    = cnt_q != '0;
    assign out_addr   = mem_q[rd_ptr_q];
    assign fill_stall = cnt_q >= (PTR_W+1)'(DEPTH-1);
    assign count      = cnt_q;
    assign ovf_err    = ovf_q;

    always_comb begin
        enq      = in_wen & in_valid & in_dirty;
        deq      = out_req & out_ack;
        full     = cnt_q == (PTR_W+1)'(DEPTH);
        // A full queue still accepts when the head drains on the same edge.
        accept   = enq & (~full | deq);
        wr_ptr_d = accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d    = cnt_q + (PTR_W+1)'(accept) - (PTR_W+1)'(deq);
        ovf_d    = ovf_q | (enq & ~accept);
        vld_d    = vld_q;
        if (deq)
            vld_d[rd_ptr_q] = 1'b0;
        // When full and draining, wr_ptr equals rd_ptr: the slot is refilled.
        if (accept)
            vld_d[wr_ptr_q] = 1'b1;
    end

    always_comb begin
        snoop_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            snoop_hit = snoop_hit | (vld_q[i] & (mem_q[i][ADDR_W-1:1] == snoop_addr));
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (accept)
                mem_q[wr_ptr_q] <= in_addr;
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule
